// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding/hazard controller.
//   entry_t      : one in-flight instruction record (valid, rd, reg_write, is_load)
//   FWD_SEL_RF   : forwarding select value meaning "read the register file"
//   sel_width()  : width of a forwarding select for a given number of entries
package hazard_pkg;

  // rd is stored at a fixed maximum width so the struct can live in a package;
  // narrower register addresses are zero-extended on entry and on compare.
  localparam int unsigned MAX_REG_ADDR_W = 8;
  localparam int unsigned FWD_SEL_RF     = 0;

  typedef struct packed {
    logic                      valid;
    logic [MAX_REG_ADDR_W-1:0] rd;
    logic                      reg_write;
    logic                      is_load;
  } entry_t;

  // Select encodes 0 (register file) plus one code per tracked entry.
  function automatic int unsigned sel_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_match_prio.sv
// Youngest-producer search for one source operand.
//   entries : in-flight records, index 0 is the youngest (EX)
//   src     : source register, zero-extended to MAX_REG_ADDR_W
//   hit     : some valid writer of src is in flight
//   is_load : the youngest matching writer is a load
//   idx     : index of the youngest matching entry (valid when hit=1)
module fwd_match_prio
  import hazard_pkg::*;
#(
  parameter int unsigned STAGES = 2,
  parameter int unsigned IDX_W  = 2
) (
  input  entry_t                    entries [STAGES],
  input  logic [MAX_REG_ADDR_W-1:0] src,
  output logic                      hit,
  output logic                      is_load,
  output logic [IDX_W-1:0]          idx
);

  // Scan oldest to youngest so the last assignment is the youngest match.
  always_comb begin
    hit     = 1'b0;
    is_load = 1'b0;
    idx     = '0;
    for (int j = int'(STAGES) - 1; j >= 0; j--) begin
      if (entries[j].valid && entries[j].reg_write && (entries[j].rd == src)) begin
        hit     = 1'b1;
        is_load = entries[j].is_load;
        idx     = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and load-use hazard controller for the in-order pipeline.
// Tracks the destination registers of in-flight instructions in a shift
// pipeline and, for both ID source operands, picks the youngest producer.
//   clk, rst          : clock, synchronous active-high reset
//   id_*              : ID-stage instruction fields
//   flush             : squash the ID instruction and entry0
//   fwd_sel_a/b       : 0 = register file, k = entry k-1 (combinational)
//   stall             : load-use hazard, hold PC and IF/ID (combinational)
// Optional (HAZARD_FWD_PERF_EN): stall_cnt, fwd_cnt saturating 16-bit counters.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter  int unsigned REG_ADDR_W = 3,
  parameter  int unsigned STAGES     = 2,
  parameter  int unsigned LOAD_LAT   = 1,
  localparam int unsigned SEL_W      = sel_width(STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic                  stall
`ifdef HAZARD_FWD_PERF_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           fwd_cnt
`endif
);

  entry_t             entries [STAGES];
  logic               hit_a, hit_b;
  logic               ld_a, ld_b;
  logic [SEL_W-1:0]   idx_a, idx_b;
  logic               haz_a, haz_b;

  fwd_match_prio #(.STAGES(STAGES), .IDX_W(SEL_W)) u_match_a (
    .entries (entries),
    .src     (MAX_REG_ADDR_W'(id_rs1)),
    .hit     (hit_a),
    .is_load (ld_a),
    .idx     (idx_a)
  );

  fwd_match_prio #(.STAGES(STAGES), .IDX_W(SEL_W)) u_match_b (
    .entries (entries),
    .src     (MAX_REG_ADDR_W'(id_rs2)),
    .hit     (hit_b),
    .is_load (ld_b),
    .idx     (idx_b)
  );

  // A load is not forwardable until it reaches entry LOAD_LAT.
  always_comb begin
    haz_a = id_valid & hit_a & ld_a & (32'(idx_a) < LOAD_LAT);
    haz_b = id_valid & hit_b & ld_b & (32'(idx_b) < LOAD_LAT);
    stall = haz_a | haz_b;
    fwd_sel_a = SEL_W'(FWD_SEL_RF);
    fwd_sel_b = SEL_W'(FWD_SEL_RF);
    if (id_valid && hit_a && !haz_a) fwd_sel_a = SEL_W'(idx_a + SEL_W'(1));
    if (id_valid && hit_b && !haz_b) fwd_sel_b = SEL_W'(idx_b + SEL_W'(1));
  end

  // Shift pipeline; entry0 takes the ID instruction or a bubble, and a
  // flush squashes whatever was in entry0 as it moves to entry1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) entries[i] <= '0;
    end else begin
      entries[0].valid     <= id_valid & ~stall & ~flush;
      entries[0].rd        <= MAX_REG_ADDR_W'(id_rd);
      entries[0].reg_write <= id_reg_write;
      entries[0].is_load   <= id_is_load;
      for (int i = 1; i < int'(STAGES); i++) begin
        entries[i] <= entries[i-1];
        if (i == 1) entries[i].valid <= entries[0].valid & ~flush;
      end
    end
  end

`ifdef HAZARD_FWD_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (id_valid && !stall && ((fwd_sel_a != '0) || (fwd_sel_b != '0)) &&
          (fwd_cnt != 16'hFFFF))
        fwd_cnt <= fwd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl (STAGES=2, LOAD_LAT=1, REG_ADDR_W=3).
module tb_hazard_fwd_ctrl;

  localparam int unsigned STAGES   = 2;
  localparam int unsigned LOAD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_is_load, flush;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic       stall;
`ifdef HAZARD_FWD_PERF_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  hazard_fwd_ctrl #(.REG_ADDR_W(3), .STAGES(STAGES), .LOAD_LAT(LOAD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .stall        (stall)
`ifdef HAZARD_FWD_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .fwd_cnt      (fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Independent reference state of the in-flight entries.
  logic       m_valid [STAGES];
  logic [2:0] m_rd    [STAGES];
  logic       m_rw    [STAGES];
  logic       m_ld    [STAGES];
  int         m_stall_cnt = 0;
  int         m_fwd_cnt   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] r1, input logic [2:0] r2,
                       input logic [2:0] rd, input logic rw, input logic ld,
                       input logic fl, input logic r);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_reg_write = rw; id_is_load = ld; flush = fl; rst = r;
  endtask

  // Reference select/stall for one operand given the model state.
  task automatic model_operand(input logic [2:0] src, output logic [1:0] sel,
                               output logic haz);
    int youngest = -1;
    for (int j = 0; j < int'(STAGES); j++)
      if (youngest < 0 && m_valid[j] && m_rw[j] && m_rd[j] == src) youngest = j;
    sel = 2'd0;
    haz = 1'b0;
    if (id_valid && youngest >= 0) begin
      if (m_ld[youngest] && youngest < int'(LOAD_LAT)) haz = 1'b1;
      else sel = 2'(youngest + 1);
    end
  endtask

  task automatic model_eval(output logic [1:0] a, output logic [1:0] b, output logic s);
    logic ha, hb;
    model_operand(id_rs1, a, ha);
    model_operand(id_rs2, b, hb);
    s = ha | hb;
  endtask

  task automatic push(input string tag, input logic [1:0] a, input logic [1:0] b,
                      input logic s);
    exp_t e;
    e.tag = tag; e.sel_a = a; e.sel_b = b; e.stall = s;
    sb_q.push_back(e);
  endtask

  // Compare pending expectations away from the edge, then advance the model.
  task automatic step();
    logic [1:0] a, b;
    logic       s;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      exp_t e = sb_q.pop_front();
      check({e.tag, ".sel_a"}, int'(fwd_sel_a), int'(e.sel_a));
      check({e.tag, ".sel_b"}, int'(fwd_sel_b), int'(e.sel_b));
      check({e.tag, ".stall"}, int'(stall), int'(e.stall));
    end
    model_eval(a, b, s);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) m_valid[i] = 1'b0;
      m_stall_cnt = 0;
      m_fwd_cnt   = 0;
    end else begin
      if (s) m_stall_cnt++;
      if (id_valid && !s && (a != 0 || b != 0)) m_fwd_cnt++;
      for (int i = int'(STAGES) - 1; i >= 1; i--) begin
        m_valid[i] = m_valid[i-1] & ~flush;
        m_rd[i] = m_rd[i-1]; m_rw[i] = m_rw[i-1]; m_ld[i] = m_ld[i-1];
      end
      m_valid[0] = id_valid & ~s & ~flush;
      m_rd[0] = id_rd; m_rw[0] = id_reg_write; m_ld[0] = id_is_load;
    end
    #1;
  endtask

  // Directed cycle with hand-derived expectations.
  task automatic cyc(input string tag, input logic v, input logic [2:0] r1,
                     input logic [2:0] r2, input logic [2:0] rd, input logic rw,
                     input logic ld, input logic fl,
                     input logic [1:0] ea, input logic [1:0] eb, input logic es);
    drive(v, r1, r2, rd, rw, ld, fl, 1'b0);
    push(tag, ea, eb, es);
    step();
  endtask

  task automatic idle2();
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [1:0] a, b;
    logic       s;
    for (int i = 0; i < int'(STAGES); i++) begin
      m_valid[i] = 1'b0; m_rd[i] = '0; m_rw[i] = 1'b0; m_ld[i] = 1'b0;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1);
    @(posedge clk); #1;
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ALU back-to-back
    cyc("alu.c0", 1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    cyc("alu.c1", 1, 3, 0, 6, 1, 0, 0, 1, 0, 0);
    cyc("alu.c2", 1, 7, 3, 0, 0, 0, 0, 0, 2, 0);
    idle2();

    // Double producer: youngest wins
    cyc("dbl.c0", 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    cyc("dbl.c1", 1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    cyc("dbl.c2", 1, 5, 1, 0, 0, 0, 0, 1, 0, 0);
    idle2();

    // Load-use: one stall cycle, then forward from entry1
    cyc("ld.c0", 1, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    cyc("ld.c1", 1, 0, 2, 4, 1, 0, 0, 0, 0, 1);
    cyc("ld.c2", 1, 0, 2, 4, 1, 0, 0, 0, 2, 0);
    idle2();

    // Non-writer, rs1==rs2
    cyc("nw.c0", 1, 0, 0, 4, 0, 0, 0, 0, 0, 0);
    cyc("nw.c1", 1, 4, 4, 0, 0, 0, 0, 0, 0, 0);
    idle2();

    // Self-reference is not a forward; register 0 forwards normally
    cyc("self.c0", 1, 6, 6, 6, 1, 0, 0, 0, 0, 0);
    cyc("r0.c0",   1, 6, 0, 0, 1, 0, 0, 1, 0, 0);
    cyc("r0.c1",   1, 0, 6, 1, 0, 0, 0, 1, 2, 0);
    idle2();

    // Flush squashes the old entry0 and the ID instruction
    cyc("fl.c0", 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc("fl.c1", 1, 1, 0, 3, 1, 0, 1, 1, 0, 0);
    cyc("fl.c2", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    idle2();

    // Reset in the middle of a load-use stall
    cyc("rs.c0", 1, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    cyc("rs.c1", 1, 0, 2, 4, 1, 0, 0, 0, 0, 1);
    drive(1, 0, 2, 4, 1, 0, 0, 1'b1);
    step();
    cyc("rs.after", 1, 0, 2, 4, 1, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_PERF_EN
    check("rs.stall_cnt", int'(stall_cnt), 0);
    check("rs.fwd_cnt", int'(fwd_cnt), 0);
`endif

    // Random traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), 1'b0);
      model_eval(a, b, s);
      push("rand", a, b, s);
      step();
    end
`ifdef HAZARD_FWD_PERF_EN
    @(negedge clk);
    check("perf.stall_cnt", int'(stall_cnt), m_stall_cnt);
    check("perf.fwd_cnt", int'(fwd_cnt), m_fwd_cnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
